// File: rtl/sa_share.sv
// Shared ISA and sequencer definitions for the systolic-array TPU control path.
package sa_share;
  localparam int ISA_BITS     = 16;
  localparam int OPCODE_BITS  = 8;
  localparam int OPERAND_BITS = ISA_BITS - OPCODE_BITS;

  localparam logic [OPCODE_BITS-1:0] OP_NOP          = 8'h00;
  localparam logic [OPCODE_BITS-1:0] OP_LOAD_DATA    = 8'h01;
  localparam logic [OPCODE_BITS-1:0] OP_LOAD_WEIGHT  = 8'h02;
  localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL      = 8'h03;
  localparam logic [OPCODE_BITS-1:0] OP_WRITE_RESULT = 8'h04;
  localparam logic [OPCODE_BITS-1:0] OP_WRITE_DATA   = 8'h05;
  localparam logic [OPCODE_BITS-1:0] OP_WRITE_WEIGHT = 8'h06;
  localparam logic [OPCODE_BITS-1:0] OP_HALT         = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_EXEC, S_DONE, S_ERR
  } seq_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Legal opcodes are the contiguous range NOP..WRITE_WEIGHT plus HALT.
  function automatic logic op_is_legal(input logic [OPCODE_BITS-1:0] op);
    return (op <= OP_WRITE_WEIGHT) || (op == OP_HALT);
  endfunction
endpackage

// File: rtl/inst_watchdog.sv
// EXEC-phase watchdog: clearable counter that saturates at its terminal count.
module inst_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)            cnt_d = '0;
    else if (en && !tc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/inst_sequencer.sv
// Program sequencer: fetches instructions from IMEM and issues them one at a time,
// waiting for the control unit's completion flag between issues.
module inst_sequencer
  import sa_share::*;
#(
  parameter int IMEM_ADDR_BITS = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [IMEM_ADDR_BITS-1:0] base_addr,
  input  logic [IMEM_ADDR_BITS:0]   inst_count,
  output logic                      imem_en,
  output logic [IMEM_ADDR_BITS-1:0] imem_addr,
  input  logic [ISA_BITS-1:0]       imem_rdata,
  output logic                      issue_valid,
  output logic [ISA_BITS-1:0]       issue_inst,
  input  logic                      issue_ready,
  input  logic                      cu_flag,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [1:0]                err_code,
  output logic [IMEM_ADDR_BITS:0]   retired
);
  seq_state_e                state_q, state_d;
  logic [IMEM_ADDR_BITS-1:0] pc_q, pc_d;
  logic [IMEM_ADDR_BITS:0]   remain_q, remain_d;
  logic [IMEM_ADDR_BITS:0]   retired_q, retired_d;
  logic [ISA_BITS-1:0]       ir_q, ir_d;
  logic                      error_q, error_d;
  logic [1:0]                err_code_q, err_code_d;
  logic                      retire, last, wd_tc;
  logic [OPCODE_BITS-1:0]    op;

  assign op   = imem_rdata[ISA_BITS-1 -: OPCODE_BITS];
  assign last = (remain_q == (IMEM_ADDR_BITS+1)'(1));

  inst_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == S_ISSUE && issue_ready),
    .en    (state_q == S_EXEC),
    .tc    (wd_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    remain_d   = remain_q;
    retired_d  = retired_q;
    ir_d       = ir_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    retire     = 1'b0;
    // abort outranks every other event once a program is running
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start && !abort) begin
          pc_d       = base_addr;
          remain_d   = inst_count;
          retired_d  = '0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          state_d    = (inst_count == '0) ? S_DONE : S_FETCH;
        end
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          ir_d = imem_rdata;
          if (op == OP_NOP || op == OP_HALT) begin
            retire  = 1'b1;
            state_d = (op == OP_HALT || last) ? S_DONE : S_FETCH;
          end else if (!op_is_legal(op)) begin
            error_d    = 1'b1;
            err_code_d = ERR_ILLEGAL;
            state_d    = S_ERR;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: if (issue_ready) state_d = S_EXEC;
        S_EXEC: begin
          if (cu_flag) begin
            retire  = 1'b1;
            state_d = last ? S_DONE : S_FETCH;
          end else if (wd_tc) begin
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = S_ERR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (retire) begin
      pc_d      = pc_q + 1'b1;
      remain_d  = remain_q - 1'b1;
      retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      remain_q   <= '0;
      retired_q  <= '0;
      ir_q       <= '0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      pc_q       <= pc_d;
      remain_q   <= remain_d;
      retired_q  <= retired_d;
      ir_q       <= ir_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    imem_en     = (state_q == S_FETCH);
    issue_valid = (state_q == S_ISSUE);
    imem_addr   = pc_q;
    issue_inst  = ir_q;
    error       = error_q;
    err_code    = err_code_q;
    retired     = retired_q;
  end
endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Program sequencer for the systolic-array TPU. It fetches 16-bit instructions (8-bit opcode, 8-bit operand) from a synchronous instruction memory and issues them one at a time to the control unit. After each issue it waits for the control unit's completion flag before fetching the next instruction. It sits between the host-loaded instruction BRAM and the control unit, and reports busy, done and error status to the host.

## Interface
- ISA_BITS, 16, instruction width
- OPCODE_BITS, 8, opcode field, instruction[15:8]
- IMEM_ADDR_BITS, 8, instruction memory address width
- TIMEOUT_CYCLES, 1024, max EXEC wait before watchdog error

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; launches program (honoured only in S_IDLE)
- abort  in  1  level; kills program
- base_addr  in  IMEM_ADDR_BITS  first instruction address, latched on start
- inst_count  in  IMEM_ADDR_BITS+1  instructions to run, latched on start
- imem_en  out  1  memory read enable
- imem_addr  out  IMEM_ADDR_BITS  memory read address
- imem_rdata  in  ISA_BITS  read data, valid the cycle after imem_en
- issue_valid  out  1  instruction valid to control unit
- issue_inst  out  ISA_BITS  instruction to control unit
- issue_ready  in  1  control unit accepts
- cu_flag  in  1  control unit completion pulse
- busy  out  1  high in any state except S_IDLE
- done  out  1  one-cycle pulse on normal completion
- error  out  1  sticky error; cleared by next accepted start
- err_code  out  2  0 none, 1 illegal opcode, 2 watchdog timeout
- retired  out  IMEM_ADDR_BITS+1  instructions retired since start

## Operation
- Opcodes: NOP=0x00, LOAD_DATA=0x01, LOAD_WEIGHT=0x02, MAT_MUL=0x03, WRITE_RESULT=0x04, WRITE_DATA=0x05, WRITE_WEIGHT=0x06, HALT=0xFF. Any other opcode is illegal.
- States: S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_EXEC, S_DONE, S_ERR.
- S_IDLE, start=1, abort=0:
  - Latch pc=base_addr and remain=inst_count.
  - Clear retired, error and err_code.
  - Go to S_DONE if inst_count==0, else S_FETCH.
- S_FETCH: imem_en=1, imem_addr=pc; go to S_WAIT.
- S_WAIT: latch imem_rdata into the instruction register, then decode:
  - NOP: retire, skip issue, go to S_FETCH or S_DONE.
  - HALT: retire, go to S_DONE regardless of remain.
  - Illegal: err_code=1, go to S_ERR.
  - Otherwise: go to S_ISSUE.
- S_ISSUE: issue_valid=1 with issue_inst held stable. On issue_valid&issue_ready, go to S_EXEC and clear the watchdog.
- S_EXEC:
  - cu_flag=1: retire, then go to S_DONE if remain==1, else S_FETCH.
  - Otherwise the watchdog increments; when it reaches TIMEOUT_CYCLES-1 with no flag, set err_code=2 and go to S_ERR.
- Retire: pc=pc+1, wrapping mod 2^IMEM_ADDR_BITS; remain−1; retired+1. NOP and HALT also decrement remain; when remain reaches 0, go to S_DONE.
- S_DONE: done=1 for one cycle, then S_IDLE.
- S_ERR: error=1, then S_IDLE. error and err_code hold until the next start.
- abort=1 in any non-IDLE state: go to S_IDLE next cycle, drop issue_valid, no done pulse, error unchanged. abort takes priority over start, cu_flag and the watchdog.
- start while busy: ignored.
- cu_flag outside S_EXEC: ignored.
- Reset mid-operation: all registers return to reset values immediately (asynchronous).

## Timing
- Reset values:
  - State S_IDLE.
  - busy, done, error, err_code, issue_valid, imem_en, imem_addr, issue_inst, retired all 0.
  - pc, remain and watchdog 0.
- All outputs are registered or decoded from state/registers; there is no combinational path from any input to any output.
- start to imem_en: 1 cycle. imem_en to imem_rdata sampled: 1 cycle. Sample to issue_valid: 1 cycle.
- Minimum per non-NOP instruction: 4 cycles (FETCH, WAIT, ISSUE with ready=1, EXEC with flag in the first cycle).
- Minimum per NOP: 2 cycles.
- issue_valid never deasserts without a handshake, except on abort or reset.
- done is asserted 1 cycle after the final retire.

## Structure
- Shared package sa_share:
  - Opcode constants.
  - State encodings.
  - ISA_BITS, OPCODE_BITS, OPERAND_BITS.
  - err_code values.
- Sub-module inst_watchdog: a counter with clear, enable and a terminal-count output, instantiated once.
- All other logic is a single FSM plus the pc, remain and retired counters.

## Test plan
- base=0x10, count=3, program {0x0105, 0x0300, 0x0420}, ready=1, cu_flag 2 cycles after each issue → issues in order, retired=3, done pulse, error=0.
- base=0xFE, count=4, all MAT_MUL → imem_addr sequence 0xFE, 0xFF, 0x00, 0x01 (wrap), retired=4.
- Program {0x0000, 0xFF00, 0x0100}, count=3 → no issue for NOP/HALT, done after HALT, retired=2, LOAD_DATA never issued.
- Opcode 0x7A at the first address → error=1, err_code=1, no issue_valid; next start clears error.
- MAT_MUL issued, cu_flag never returns, TIMEOUT_CYCLES=16 → err_code=2 after 16 EXEC cycles. Separately, issue_ready held 0 for 5 cycles → issue_inst stable throughout.
- abort asserted in S_EXEC → S_IDLE next cycle, busy=0, no done pulse. Reset pulse mid-S_ISSUE → all outputs 0 asynchronously. start asserted with count=0 → done pulse 1 cycle later, no fetch.
